avg_n_per_clk_blk: RTL and testbench
====================================

Name: avg_n_per_clk_blk

Overview:
- Averages NUM_INPUTS lanes per valid beat, then accumulates 2^LOG2_BEATS beats into one block average (NUM_INPUTS*2^LOG2_BEATS samples per result).
- Pipelined adder tree, block accumulator, beat counter, shift-divide, registered output.
- Successor to the single-beat averager.
- Sits after multi-sample-per-clock front ends and decimates the stream to one averaged value per block.

Parameters:
- NUM_INPUTS, 16, lanes per beat; power of 2, >=1.
- DWIDTH, 8, bits per unsigned input lane and per output.
- LOG2_BEATS, 2, log2 of beats per block; 0 gives one result per beat.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_dat_vector  in  NUM_INPUTS*DWIDTH  lane k at bits [k*DWIDTH +: DWIDTH].
- i_dat_valid  in  1  beat qualifier.
- i_clear  in  1  synchronous flush; discards the partial block.
- o_avg  out  DWIDTH  block average.
- o_avg_valid  out  1  one-cycle pulse per completed block.
- o_busy  out  1  high while any beat is in the pipeline or the accumulator holds a partial block.

Behaviour:
- Only one clock domain. rst is asynchronous, active-high. While rst is high: all pipeline registers, valids, accumulator, beat counter, o_avg, o_avg_valid and o_busy are 0.
- Widths:
  - L = $clog2(NUM_INPUTS).
  - S = L + LOG2_BEATS.
  - Tree width DWIDTH+L.
  - Accumulator width DWIDTH+S.
  - No overflow is possible by construction.
- Adder tree:
  - L registered levels, each level pairing adjacent lanes; valid travels alongside the data.
  - L=0: the lane passes straight to the accumulator stage.
- Accumulate stage, on each tree-output valid:
  - If beat count < 2^LOG2_BEATS-1: acc <= acc + tree_sum; count++.
  - If count == 2^LOG2_BEATS-1: o_avg <= (acc + tree_sum) >> S; o_avg_valid <= 1; acc <= 0; count <= 0.
- Latency: i_dat_valid of the final beat of a block -> o_avg_valid high L+1 cycles later.
- Throughput: one beat per clock, no backpressure. Back-to-back blocks produce pulses every 2^LOG2_BEATS cycles.
- Gaps: idle cycles (i_dat_valid=0) are ignored and do not advance the counter. o_avg holds its last value between pulses.
- i_clear:
  - Same cycle: zeroes acc, count and all tree valid bits. The beat presented with i_clear is discarded (clear has priority).
  - Next cycle: o_avg_valid is 0. o_avg keeps its last value.
  - A result whose pulse coincides with i_clear still pulses; the clear affects only subsequent data.
- o_busy = OR of the tree valids | (count != 0). It is registered-path derived, with no combinational path from the inputs.
- Reset mid-block: partial data is lost. The first full block after rst falls is correct.
- LOG2_BEATS=0: the counter is a constant 0 and every tree-output valid produces a result.

Optional Feature:
AVG_ROUND_EN:
- Defined: o_avg = (acc + tree_sum + 2^(S-1)) >> S, i.e. round half-up. All-ones inputs still yield all-ones, so no saturation logic is needed. For S=0 there is no rounding term.
- Undefined: truncation (floor), as stated under Behaviour. Latency is identical in both builds.

Test Plan:
All scenarios use NUM_INPUTS=4, DWIDTH=8, LOG2_BEATS=2, giving L=2, S=4, 16 samples per block.
1. Four consecutive beats, every lane 8'h10 -> single o_avg_valid pulse 3 cycles after the 4th beat, o_avg=8'h10. o_busy falls on the same cycle.
2. Four beats, all lanes 8'hFF -> o_avg=8'hFF in both builds. Then eight consecutive beats of 8'h20 -> two pulses 4 cycles apart, each with o_avg=8'h20.
3. Sixteen samples summing to 24 (eight lanes =3, rest 0) -> o_avg=1 without AVG_ROUND_EN, 2 with it. A sum of 23 -> 1 in both builds.
4. Four beats of 8'h40 separated by 0-3 random idle cycles -> exactly one pulse, o_avg=8'h40, arriving 3 cycles after the last valid beat.
5. Two beats of 8'hFF, then i_clear asserted together with a third 8'hFF beat, then four beats of 8'h08 -> one pulse only, o_avg=8'h08. o_busy is 0 the cycle after the clear.
6. rst pulsed asynchronously between clock edges after two beats of 8'h80 -> outputs 0 immediately. A following 4-beat block of 8'h04 -> o_avg=8'h04.

Source files
------------

// File: rtl/avg_n_per_clk_blk.sv
// Block averager: pipelined adder tree over NUM_INPUTS lanes, then accumulate 2^LOG2_BEATS beats and shift-divide.
// Define AVG_ROUND_EN for round-half-up results; otherwise the average is truncated (floor).
module avg_n_per_clk_blk #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 8,
  parameter int LOG2_BEATS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_INPUTS*DWIDTH-1:0] i_dat_vector,
  input  logic                         i_dat_valid,
  input  logic                         i_clear,
  output logic [DWIDTH-1:0]            o_avg,
  output logic                         o_avg_valid,
  output logic                         o_busy
);

  localparam int L     = $clog2(NUM_INPUTS);
  localparam int S     = L + LOG2_BEATS;
  localparam int TW    = DWIDTH + L;
  localparam int AW    = DWIDTH + S;
  localparam int BEATS = 1 << LOG2_BEATS;
  localparam int CW    = (LOG2_BEATS > 0) ? LOG2_BEATS : 1;

`ifdef AVG_ROUND_EN
  localparam logic [AW-1:0] RND = AW'((1 << S) >> 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  logic [TW-1:0] tree_sum;
  logic          tree_vld;
  logic          tree_busy;

  generate
    if (L == 0) begin : g_pass
      assign tree_sum  = i_dat_vector;
      assign tree_vld  = i_dat_valid & ~i_clear;
      assign tree_busy = 1'b0;
    end else begin : g_tree
      // heap[0..N-1] are the lanes; heap[N+j] mirrors node_q[j]. Node j sums heap[2j] and heap[2j+1],
      // so each tree level lands one register stage after the level it consumes.
      logic [TW-1:0] heap   [2*NUM_INPUTS-2];
      logic [TW-1:0] node_q [NUM_INPUTS-1];
      logic [L-1:0]  vld_q;

      always_comb begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
          heap[k] = TW'(i_dat_vector[k*DWIDTH +: DWIDTH]);
        end
        for (int j = 0; j < NUM_INPUTS - 2; j++) begin
          heap[NUM_INPUTS+j] = node_q[j];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < NUM_INPUTS - 1; j++) begin
            node_q[j] <= '0;
          end
          vld_q <= '0;
        end else begin
          for (int j = 0; j < NUM_INPUTS - 1; j++) begin
            node_q[j] <= heap[2*j] + heap[2*j+1];
          end
          vld_q <= i_clear ? '0 : ((vld_q << 1) | L'(i_dat_valid));
        end
      end

      assign tree_sum  = node_q[NUM_INPUTS-2];
      assign tree_vld  = vld_q[L-1];
      assign tree_busy = |vld_q;
    end
  endgenerate

  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_next;
  logic [DWIDTH-1:0] avg_next;
  logic [CW-1:0]     count;
  logic              last_beat;

  assign acc_next  = acc + AW'(tree_sum);
  assign avg_next  = DWIDTH'((acc_next + RND) >> S);
  assign last_beat = (count == CW'(BEATS - 1));
  assign o_busy    = tree_busy | (count != '0);

  // Clear wins over a completing beat; a pulse already on the output is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      count       <= '0;
      o_avg       <= '0;
      o_avg_valid <= 1'b0;
    end else begin
      o_avg_valid <= 1'b0;
      if (i_clear) begin
        acc   <= '0;
        count <= '0;
      end else if (tree_vld) begin
        if (last_beat) begin
          o_avg       <= avg_next;
          o_avg_valid <= 1'b1;
          acc         <= '0;
          count       <= '0;
        end else begin
          acc   <= acc_next;
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_avg_n_per_clk_blk.sv
// Bench for avg_n_per_clk_blk (4 lanes x 4 beats): transaction-level model checked every cycle,
// plus hand-computed pulse counts, values and latencies per directed scenario.
module tb_avg_n_per_clk_blk;

  localparam int NI = 4;
  localparam int DW = 8;
  localparam int LB = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NI*DW-1:0] i_dat_vector = '0;
  logic             i_dat_valid = 1'b0;
  logic             i_clear = 1'b0;
  logic [DW-1:0]    o_avg;
  logic             o_avg_valid;
  logic             o_busy;

  int n_checks = 0;
  int n_errors = 0;

  avg_n_per_clk_blk #(.NUM_INPUTS(NI), .DWIDTH(DW), .LOG2_BEATS(LB)) dut (
    .clk(clk), .rst(rst), .i_dat_vector(i_dat_vector), .i_dat_valid(i_dat_valid),
    .i_clear(i_clear), .o_avg(o_avg), .o_avg_valid(o_avg_valid), .o_busy(o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A beat accepted at edge e reaches the accumulator at edge e+2; 4 beats make a block of 16 samples.
  int            edge_n = 0;
  int            fly_edge[$];
  int            fly_sum[$];
  int            m_total = 0;
  int            m_cnt = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_avg = '0;
  logic [DW-1:0] exp_q[$];

  function automatic int lane_sum(input logic [NI*DW-1:0] v);
    int s = 0;
    for (int k = 0; k < NI; k++) s += int'(v[k*DW +: DW]);
    return s;
  endfunction

  function automatic logic [DW-1:0] blk_avg(input int total);
`ifdef AVG_ROUND_EN
    return DW'((total + 8) / 16);
`else
    return DW'(total / 16);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fly_edge.delete();
      fly_sum.delete();
      exp_q.delete();
      m_total = 0;
      m_cnt   = 0;
      m_valid = 1'b0;
      m_avg   = '0;
    end else begin
      edge_n++;
      m_valid = 1'b0;
      if (i_clear) begin
        fly_edge.delete();
        fly_sum.delete();
        m_total = 0;
        m_cnt   = 0;
      end else begin
        if (fly_edge.size() > 0 && fly_edge[0] == edge_n - 2) begin
          void'(fly_edge.pop_front());
          m_total += fly_sum.pop_front();
          m_cnt++;
          if (m_cnt == (1 << LB)) begin
            m_avg   = blk_avg(m_total);
            m_valid = 1'b1;
            exp_q.push_back(m_avg);
            m_total = 0;
            m_cnt   = 0;
          end
        end
        if (i_dat_valid) begin
          fly_edge.push_back(edge_n);
          fly_sum.push_back(lane_sum(i_dat_vector));
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic          run_chk = 1'b0;
  int            p_edge[$];
  logic [DW-1:0] p_val[$];
  logic          p_busy[$];

  always @(negedge clk) begin
    if (!rst && run_chk) begin
      check("cyc_avg_valid", o_avg_valid, m_valid);
      check("cyc_avg", o_avg, m_avg);
      check("cyc_busy", o_busy, (fly_edge.size() != 0 || m_cnt != 0));
      if (m_valid) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
        else check("scoreboard", o_avg, exp_q.pop_front());
      end
    end
    if (o_avg_valid) begin
      p_edge.push_back(edge_n);
      p_val.push_back(o_avg);
      p_busy.push_back(o_busy);
    end
  end

  // ---------------- driver tasks ----------------
  int last_drive = 0;

  task automatic send(input logic [NI*DW-1:0] v, input logic vld, input logic clr);
    i_dat_vector = v;
    i_dat_valid  = vld;
    i_clear      = clr;
    if (vld) last_drive = edge_n;
    @(posedge clk);
    #1;
    i_dat_vector = '0;
    i_dat_valid  = 1'b0;
    i_clear      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) send('0, 1'b0, 1'b0);
  endtask

  task automatic p_reset();
    p_edge.delete();
    p_val.delete();
    p_busy.delete();
  endtask

  task automatic expect_one(input string name, input logic [DW-1:0] val);
    check({name, "_pulses"}, p_edge.size(), 1);
    if (p_edge.size() >= 1) begin
      check({name, "_val"}, p_val[0], val);
      check({name, "_lat"}, p_edge[0] - last_drive, 3);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_avg", o_avg, 0);
    check("rst_avg_valid", o_avg_valid, 0);
    check("rst_busy", o_busy, 0);
    rst = 1'b0;
    run_chk = 1'b1;
    idle(2);

    // 1: uniform 0x10 block
    p_reset();
    repeat (4) send(32'h10101010, 1'b1, 1'b0);
    idle(8);
    expect_one("t1", 8'h10);
    if (p_busy.size() >= 1) check("t1_busy_at_pulse", p_busy[0], 0);

    // 2: all-ones, then two back-to-back blocks
    p_reset();
    repeat (4) send(32'hFFFFFFFF, 1'b1, 1'b0);
    idle(8);
    expect_one("t2_ff", 8'hFF);
    p_reset();
    repeat (8) send(32'h20202020, 1'b1, 1'b0);
    idle(8);
    check("t2_b2b_pulses", p_edge.size(), 2);
    if (p_edge.size() >= 2) begin
      check("t2_b2b_val0", p_val[0], 8'h20);
      check("t2_b2b_val1", p_val[1], 8'h20);
      check("t2_b2b_spacing", p_edge[1] - p_edge[0], 4);
    end

    // 3: rounding boundary, sum 24 then sum 23
    p_reset();
    send(32'h03030303, 1'b1, 1'b0);
    send(32'h03030303, 1'b1, 1'b0);
    send(32'h00000000, 1'b1, 1'b0);
    send(32'h00000000, 1'b1, 1'b0);
    idle(8);
`ifdef AVG_ROUND_EN
    expect_one("t3_sum24", 8'd2);
`else
    expect_one("t3_sum24", 8'd1);
`endif
    p_reset();
    send(32'h03030303, 1'b1, 1'b0);
    send(32'h03030302, 1'b1, 1'b0);
    send(32'h00000000, 1'b1, 1'b0);
    send(32'h00000000, 1'b1, 1'b0);
    idle(8);
    expect_one("t3_sum23", 8'd1);

    // 4: beats separated by random idle gaps
    p_reset();
    for (int i = 0; i < 4; i++) begin
      send(32'h40404040, 1'b1, 1'b0);
      if (i < 3) idle($urandom_range(0, 3));
    end
    idle(8);
    expect_one("t4_gaps", 8'h40);

    // 5: clear discards the partial block
    p_reset();
    send(32'hFFFFFFFF, 1'b1, 1'b0);
    send(32'hFFFFFFFF, 1'b1, 1'b0);
    send(32'hFFFFFFFF, 1'b1, 1'b1);
    check("t5_busy_after_clear", o_busy, 0);
    check("t5_valid_after_clear", o_avg_valid, 0);
    repeat (4) send(32'h08080808, 1'b1, 1'b0);
    idle(8);
    expect_one("t5_clear", 8'h08);

    // 6: asynchronous reset mid-block
    p_reset();
    send(32'h80808080, 1'b1, 1'b0);
    send(32'h80808080, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_avg", o_avg, 0);
    check("t6_rst_avg_valid", o_avg_valid, 0);
    check("t6_rst_busy", o_busy, 0);
    #1 rst = 1'b0;
    repeat (4) send(32'h04040404, 1'b1, 1'b0);
    idle(8);
    expect_one("t6_after_rst", 8'h04);

    // 7: distinct lane values exercise the tree pairing
    p_reset();
    repeat (4) send(32'h40302010, 1'b1, 1'b0);
    idle(8);
    expect_one("t7_lanes", 8'h28);
    p_reset();
    send(32'h01020304, 1'b1, 1'b0);
    send(32'h05060708, 1'b1, 1'b0);
    send(32'h090A0B0C, 1'b1, 1'b0);
    send(32'h0D0E0F10, 1'b1, 1'b0);
    idle(8);
`ifdef AVG_ROUND_EN
    expect_one("t7_sum136", 8'd9);
`else
    expect_one("t7_sum136", 8'd8);
`endif

    check("final_scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
